// File: rtl/irrigation_pkg.sv
// Shared constants and types for the irrigation sensor front end.
package irrigation_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;
  localparam int unsigned NUM_SENSORS             = 6;

  localparam int unsigned CH_H  = 0;
  localparam int unsigned CH_M  = 1;
  localparam int unsigned CH_L  = 2;
  localparam int unsigned CH_US = 3;
  localparam int unsigned CH_UA = 4;
  localparam int unsigned CH_T  = 5;

  // Tank triple ordered {h, m, l}
  typedef logic [2:0] level_t;

  localparam level_t LVL_EMPTY = 3'b000;
  localparam level_t LVL_LOW   = 3'b001;
  localparam level_t LVL_MID   = 3'b011;
  localparam level_t LVL_FULL  = 3'b111;

  typedef struct packed {
    logic h;
    logic m;
    logic l;
    logic us;
    logic ua;
    logic t;
  } sensors_t;

  function automatic logic level_ok(level_t v);
    return (v == LVL_EMPTY) || (v == LVL_LOW) || (v == LVL_MID) || (v == LVL_FULL);
  endfunction

endpackage

// File: rtl/sensor_conditioner_if.sv
// Raw sensor inputs and conditioned outputs of the sensor conditioner.
interface sensor_conditioner_if;

  logic h_raw, m_raw, l_raw, us_raw, ua_raw, t_raw;
  logic h, m, l, us, ua, t;
  logic level_err, valid, changed;

  modport master (
    output h_raw, m_raw, l_raw, us_raw, ua_raw, t_raw,
    input  h, m, l, us, ua, t, level_err, valid, changed
  );

  modport slave (
    input  h_raw, m_raw, l_raw, us_raw, ua_raw, t_raw,
    output h, m, l, us, ua, t, level_err, valid, changed
  );

endinterface

// File: rtl/debounce_channel.sv
// One sensor channel: 2-flop synchronizer followed by a qualify-then-commit debouncer.
module debounce_channel
  import irrigation_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_st_nxt_c
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1, r_s2, r_st;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_st_nxt;

  // Any cycle where the synchronized input matches the stable value restarts qualification
  always_comb begin
    w_st_nxt  = r_st;
    w_cnt_nxt = '0;
    if (r_s2 != r_st) begin
      if (r_cnt == CNT_LAST) w_st_nxt  = r_s2;
      else                   w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_cnt <= '0;
      r_st  <= 1'b0;
    end else begin
      r_s1  <= i_raw;
      r_s2  <= r_s1;
      r_cnt <= w_cnt_nxt;
      r_st  <= w_st_nxt;
    end
  end

  // Next stable value lets the parent register its outputs on the same edge as r_st
  assign o_st_nxt_c = w_st_nxt;

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces six sensor switches, filters implausible tank levels, flags startup and changes.
module sensor_conditioner
  import irrigation_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  sensor_conditioner_if.slave  bus
);

  localparam int unsigned   SC_MAX  = DEBOUNCE_CYCLES + 2;
  localparam int unsigned   SC_W    = $clog2(SC_MAX + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SC_MAX);
  localparam logic [SC_W-1:0] SC_FIRE = SC_W'(SC_MAX - 1);

  logic [NUM_SENSORS-1:0] w_raw;
  logic [NUM_SENSORS-1:0] w_st_nxt;

  level_t    w_lvl_nxt;
  level_t    w_lc_nxt;
  logic      w_lvl_ok;
  sensors_t  w_out_nxt;

  // r_out.h/m/l is the last consistent tank triple
  sensors_t  r_out;
  logic      r_level_err;
  logic      r_valid;
  logic      r_changed;
  logic [SC_W-1:0] r_sc;

  assign w_raw[CH_H]  = bus.h_raw;
  assign w_raw[CH_M]  = bus.m_raw;
  assign w_raw[CH_L]  = bus.l_raw;
  assign w_raw[CH_US] = bus.us_raw;
  assign w_raw[CH_UA] = bus.ua_raw;
  assign w_raw[CH_T]  = bus.t_raw;

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_ch
    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk        (clk),
      .reset      (reset),
      .i_raw      (w_raw[g]),
      .o_st_nxt_c (w_st_nxt[g])
    );
  end

  always_comb begin
    w_lvl_nxt = {w_st_nxt[CH_H], w_st_nxt[CH_M], w_st_nxt[CH_L]};
    w_lvl_ok  = level_ok(w_lvl_nxt);
    w_lc_nxt  = w_lvl_ok ? w_lvl_nxt : level_t'({r_out.h, r_out.m, r_out.l});
    w_out_nxt = sensors_t'({w_lc_nxt, w_st_nxt[CH_US], w_st_nxt[CH_UA], w_st_nxt[CH_T]});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out       <= '0;
      r_level_err <= 1'b0;
      r_valid     <= 1'b0;
      r_changed   <= 1'b0;
      r_sc        <= '0;
    end else begin
      r_out       <= w_out_nxt;
      r_level_err <= !w_lvl_ok;
      if (r_sc != SC_LAST) r_sc    <= r_sc + SC_W'(1);
      if (r_sc == SC_FIRE) r_valid <= 1'b1;
      // Uses the pre-edge valid so the settling update itself never pulses
      r_changed   <= r_valid && (w_out_nxt != r_out);
    end
  end

  assign bus.h         = r_out.h;
  assign bus.m         = r_out.m;
  assign bus.l         = r_out.l;
  assign bus.us        = r_out.us;
  assign bus.ua        = r_out.ua;
  assign bus.t         = r_out.t;
  assign bus.level_err = r_level_err;
  assign bus.valid     = r_valid;
  assign bus.changed   = r_changed;

endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Input conditioning stage sitting directly upstream of the irrigation system top: it synchronizes and debounces the six raw sensor switches (tank levels h/m/l, soil humidity us, air humidity ua, temperature t). It also rejects physically impossible tank-level combinations before they reach the alarm, inlet valve and irrigation logic. Outputs are glitch-free, registered sensor levels plus a validity flag, a level-fault flag and a one-cycle change pulse.

## Interface
- DEBOUNCE_CYCLES, default 16: consecutive cycles a synchronized input must differ from its stable value before the stable value updates; legal range ≥ 2. Board builds override to 50000.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- h_raw, m_raw, l_raw  in  1 each  raw tank-level switches: high, mid, low.
- us_raw, ua_raw, t_raw  in  1 each  raw soil-humidity, air-humidity and temperature switches.
- h, m, l  out  1 each  conditioned tank levels; always a consistent triple.
- us, ua, t  out  1 each  conditioned sensors.
- level_err  out  1  debounced tank triple is inconsistent.
- valid  out  1  startup settling complete.
- changed  out  1  one-cycle pulse when any conditioned output changes.

## Operation
- Per channel: 2-flop synchronizer (s1, s2), counter cnt, stable register st.
- Debounce: if s2 == st then cnt ← 0; else if cnt == DEBOUNCE_CYCLES-1 then st ← s2 and cnt ← 0; else cnt ← cnt+1. A single cycle with s2 == st restarts qualification.
- Counter width: $clog2(DEBOUNCE_CYCLES). Never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Level plausibility on the debounced triple {st_h, st_m, st_l}:
  - Consistent set: 000, 001, 011, 111.
  - Any other pattern: level_err = 1 and h/m/l hold the last consistent triple (register lc, reset 000).
  - Consistent pattern: lc ← triple and level_err = 0.
- us/ua/t equal their st directly; no plausibility check.
- Startup: counter sc counts from 0 after reset release; valid rises when sc reaches DEBOUNCE_CYCLES+2 and stays high until the next reset.
- changed = 1 for exactly one cycle, the first cycle in which any of h,m,l,us,ua,t shows a new value. It is suppressed while valid = 0.
- Multiple channels updating on the same edge produce one changed pulse.
- A level_err transition alone, with outputs unchanged, does not pulse changed.

## Timing
- Reset values:
  - h, m, l, us, ua, t = 0; level_err = 0; valid = 0; changed = 0.
  - All s1, s2, cnt, st, lc and sc registers = 0.
- Reset has priority over everything, including mid-count. Partial counts are discarded.
- Latency: a raw change held stable from before edge k appears on the output after edge k+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges.
  - changed and level_err update on that same edge.
- Rejection: any pulse whose synchronized width is < DEBOUNCE_CYCLES cycles has no effect on outputs.
- valid goes high after edge DEBOUNCE_CYCLES+2 following the last reset-high edge. Raw values held through reset are therefore already visible when valid rises.
- All outputs are registered; no combinational path from raw inputs to outputs.

## Structure
- Shared package irrigation_pkg holds:
  - default DEBOUNCE_CYCLES;
  - NUM_SENSORS = 6;
  - channel index constants CH_H, CH_M, CH_L, CH_US, CH_UA, CH_T;
  - consistent-level encodings LVL_EMPTY = 000, LVL_LOW = 001, LVL_MID = 011, LVL_FULL = 111.
- One sub-module, debounce_channel (synchronizer, counter, stable register, parameter DEBOUNCE_CYCLES), is instantiated six times.
- Plausibility filter, startup counter and change detector live in sensor_conditioner.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset: raw = 111 levels, us = 1; reset held 3 edges. During reset all outputs = 0. After release, valid = 1 after edge 6, with h,m,l = 111 and us = 1 simultaneously; no changed pulse.
- Clean edge: after valid, l_raw 0→1 before edge k → l = 1 after edge k+5; changed high exactly one cycle; level_err = 0.
- Glitch: us_raw high for 3 cycles then low → us stays 0 and changed stays 0. Repeat with 4 cycles → us = 1.
- Implausible level: from 001, raw goes to 101 → level_err = 1 after edge k+5 while h,m,l stay 001. Raise m_raw → h,m,l = 111, level_err = 0, one changed pulse.
- Reset mid-count: t_raw rises; reset is asserted when cnt = 2 → t = 0 and valid = 0. With t_raw still high, t = 1 and valid = 1 together after edge 6 post-release.
- Simultaneous: ua_raw and t_raw toggle in the same cycle → both outputs update on the same edge with a single one-cycle changed pulse.
